// File: rtl/dual_dff_preset_clear_pkg.sv
// Shared definitions for the dual D flip-flop cell: default channel count and
// decoding of the per-channel asynchronous control pair.
package dual_dff_preset_clear_pkg;

  localparam int DFF_CHANNELS = 2;

  typedef enum logic [1:0] {
    CTRL_NORMAL = 2'b00,
    CTRL_PRESET = 2'b01,
    CTRL_CLEAR  = 2'b10,
    CTRL_BOTH   = 2'b11
  } ctrl_mode_e;

  // Active-low controls collapsed into one mode value; clear and preset together
  // is the 74LS74 "both outputs high" case.
  function automatic ctrl_mode_e ctrl_mode(input logic pr_n, input logic clr_n);
    ctrl_mode_e mode;
    unique case ({pr_n, clr_n})
      2'b11:   mode = CTRL_NORMAL;
      2'b01:   mode = CTRL_PRESET;
      2'b10:   mode = CTRL_CLEAR;
      default: mode = CTRL_BOTH;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/dual_dff_preset_clear_if.sv
// Per-channel data, control and output bundle of the dual flip-flop cell.
// Handshake: none; every signal is level-meaningful on every cycle, bit i = channel i+1.
interface dual_dff_preset_clear_if
  import dual_dff_preset_clear_pkg::*;
#(
  parameter int CHANNELS = DFF_CHANNELS
);

  logic [CHANNELS-1:0] D;
  logic [CHANNELS-1:0] PR_n;
  logic [CHANNELS-1:0] CLR_n;
  logic [CHANNELS-1:0] Q;
  logic [CHANNELS-1:0] Q_n;

  modport master (
    output D,
    output PR_n,
    output CLR_n,
    input  Q,
    input  Q_n
  );

  modport slave (
    input  D,
    input  PR_n,
    input  CLR_n,
    output Q,
    output Q_n
  );

endinterface

// File: rtl/dual_dff_preset_clear_cell.sv
// One channel: D flip-flop with asynchronous active-low clear/preset (clear wins)
// and synchronous global reset, plus the 74LS74 output decode.
module dual_dff_preset_clear_cell
  import dual_dff_preset_clear_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  input  logic i_pr_n,
  input  logic i_clr_n,
  output logic o_q,
  output logic o_q_n
);

  logic       r_q;
  ctrl_mode_e w_mode;

  // Reset sits below the async controls so it never overrides an active preset.
  always_ff @(posedge i_clk or negedge i_clr_n or negedge i_pr_n) begin
    if (!i_clr_n) begin
      r_q <= 1'b0;
    end else if (!i_pr_n) begin
      r_q <= 1'b1;
    end else if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign w_mode = ctrl_mode(i_pr_n, i_clr_n);

  // Outputs follow the controls immediately, independent of the stored bit.
  always_comb begin
    o_q   = r_q;
    o_q_n = ~r_q;
    unique case (w_mode)
      CTRL_PRESET: begin
        o_q   = 1'b1;
        o_q_n = 1'b0;
      end
      CTRL_CLEAR: begin
        o_q   = 1'b0;
        o_q_n = 1'b1;
      end
      CTRL_BOTH: begin
        o_q   = 1'b1;
        o_q_n = 1'b1;
      end
      default: begin
        o_q   = r_q;
        o_q_n = ~r_q;
      end
    endcase
  end

endmodule

// File: rtl/dual_dff_preset_clear.sv
// Dual positive-edge D flip-flop with per-channel preset/clear (74LS74 function)
// and a shared clock and synchronous reset; one cell per channel.
module dual_dff_preset_clear
  import dual_dff_preset_clear_pkg::*;
#(
  parameter int CHANNELS = DFF_CHANNELS
) (
  input  logic                    CLK,
  input  logic                    RST,
  dual_dff_preset_clear_if.slave  bus
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    dual_dff_preset_clear_cell u_cell (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_d     (bus.D[g]),
      .i_pr_n  (bus.PR_n[g]),
      .i_clr_n (bus.CLR_n[g]),
      .o_q     (bus.Q[g]),
      .o_q_n   (bus.Q_n[g])
    );
  end

endmodule

// File: tb/tb_dual_dff_preset_clear.sv
// Bench for the dual preset/clear flip-flop: directed 74LS74 scenarios followed
// by randomized traffic, scored against a per-channel behavioural model.
module tb_dual_dff_preset_clear;

  localparam int CH = 2;
  localparam int W  = 2 * CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_dff_preset_clear_if #(.CHANNELS(CH)) bus ();

  dual_dff_preset_clear #(.CHANNELS(CH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  logic [CH-1:0] d_v   = '0;
  logic [CH-1:0] pr_v  = '1;
  logic [CH-1:0] clr_v = '1;
  bit   [CH-1:0] m_q   = '0;

  // Stored bit per channel, evaluated at each rising edge from the rules.
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (!clr_v[i])      m_q[i] = 1'b0;
      else if (!pr_v[i])  m_q[i] = 1'b1;
      else if (rst)       m_q[i] = 1'b0;
      else                m_q[i] = d_v[i];
    end
  end

  function automatic logic [W-1:0] model_out();
    logic [CH-1:0] q;
    logic [CH-1:0] qn;
    for (int i = 0; i < CH; i++) begin
      if (!pr_v[i] && !clr_v[i]) begin q[i] = 1'b1; qn[i] = 1'b1; end
      else if (!pr_v[i])         begin q[i] = 1'b1; qn[i] = 1'b0; end
      else if (!clr_v[i])        begin q[i] = 1'b0; qn[i] = 1'b1; end
      else                       begin q[i] = m_q[i]; qn[i] = ~m_q[i]; end
    end
    return {q, qn};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  event         chk_ev;
  int           n_tests = 0;
  int           n_fail  = 0;

  initial begin
    forever begin
      @(chk_ev);
      #1;
      while (exp_q.size() != 0) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.Q, bus.Q_n};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: {Q,Q_n} got %b expected %b at %0t", nm, a, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [CH-1:0] d, input logic [CH-1:0] pr,
                       input logic [CH-1:0] clr, input logic r);
    @(negedge clk);
    d_v = d; pr_v = pr; clr_v = clr; rst = r;
    bus.D = d; bus.PR_n = pr; bus.CLR_n = clr;
    for (int i = 0; i < CH; i++) begin
      if (!clr[i])     m_q[i] = 1'b0;
      else if (!pr[i]) m_q[i] = 1'b1;
    end
  endtask

  task automatic check(input string nm);
    exp_q.push_back(model_out());
    name_q.push_back(nm);
    -> chk_ev;
    #2;
  endtask

  task automatic edge_check(input string nm);
    @(posedge clk);
    #2;
    check(nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.D = '0; bus.PR_n = '1; bus.CLR_n = '1;

    drive(2'b00, 2'b11, 2'b11, 1'b1);
    repeat (2) @(posedge clk);
    drive(2'b00, 2'b11, 2'b11, 1'b0);
    check("reset_state");

    drive(2'b01, 2'b11, 2'b11, 1'b0);
    check("d01_before_edge");
    edge_check("load_01");
    drive(2'b10, 2'b11, 2'b11, 1'b0);
    check("d_toggle_hold");
    #1 bus.D = 2'b01; d_v = 2'b01;
    #1 bus.D = 2'b10; d_v = 2'b10;
    check("d_toggle_hold2");
    edge_check("load_10");

    drive(2'b11, 2'b11, 2'b11, 1'b0);
    edge_check("load_11");
    drive(2'b11, 2'b11, 2'b10, 1'b0);
    check("clr0_immediate");
    edge_check("clr0_held_edge");
    drive(2'b11, 2'b11, 2'b11, 1'b0);
    check("clr0_release_no_load");
    edge_check("clr0_after_release");

    drive(2'b01, 2'b01, 2'b11, 1'b0);
    check("pr1_immediate");
    drive(2'b01, 2'b01, 2'b11, 1'b1);
    edge_check("pr1_rst_ignored");
    drive(2'b01, 2'b11, 2'b11, 1'b0);
    check("pr1_release_no_load");
    edge_check("pr1_after_release");

    drive(2'b01, 2'b10, 2'b10, 1'b0);
    check("both_low_ch0");
    edge_check("both_low_ch0_edge");
    drive(2'b01, 2'b11, 2'b11, 1'b0);
    check("both_release_q0");

    drive(2'b00, 2'b01, 2'b10, 1'b0);
    check("independence");
    edge_check("independence_edge");

    // Random traffic. Releasing clear while preset stays low is steered to a
    // full release, since the stored bit only re-evaluates on edges then.
    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0] nd;
      logic [CH-1:0] np;
      logic [CH-1:0] nc;
      logic          nr;
      nd = CH'($urandom);
      nr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < CH; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        np[i] = !(sel == 6 || sel == 7 || sel == 9);
        nc[i] = !(sel == 8 || sel == 9);
        if (!pr_v[i] && !clr_v[i] && !np[i] && nc[i]) begin
          np[i] = 1'b1;
        end
      end
      drive(nd, np, nc, nr);
      check("rand_async");
      if ($urandom_range(0, 1) == 1) edge_check("rand_edge");
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
